avalon_sram_ctrl: RTL
=====================

AVALON_SRAM_CTRL -- requirements
Module: avalon_sram_ctrl

Interface
REQ-001 Parameter SRAM_AW, default 18: SRAM half-word address width in bits.
REQ-002 Parameter WAIT_CYCLES, default 1: extra cycles per SRAM half-word phase; legal range 1..7.
REQ-003 clk  input  1  single clock for the block.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 dbus_avalon_req  input  avalon_req_t  Avalon-MM request from the LSU: read, write, address, writedata, byte_enable.
REQ-006 dbus_avalon_resp  output  avalon_resp_t  Avalon-MM response to the LSU: readdata, waitrequest.
REQ-007 sram_addr  output  SRAM_AW  half-word address; equals {dbus_avalon_req.address[SRAM_AW:2], half}, where half is 0 for the low phase and 1 for the high phase.
REQ-008 sram_dq_o  output  16  write data.
REQ-009 sram_dq_i  input  16  read data.
REQ-010 sram_dq_oe  output  1  data drive enable.
REQ-011 sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  active-low SRAM strobes.

Function
REQ-012 FSM states SHALL be IDLE, LO, HI and DONE.
REQ-013 IDLE with write=1 SHALL go to LO; IDLE with read=1 (and write=0) SHALL go to LO; write has priority if both are 1.
REQ-014 Each LO or HI phase SHALL last WAIT_CYCLES+1 cycles, timed by a phase counter; on expiry LO goes to HI and HI goes to DONE.
REQ-015 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-016 waitrequest SHALL be (read|write) & (state != DONE), combinationally, so it is high in the IDLE accept cycle.
REQ-017 A full word access SHALL hold waitrequest high for 2*(WAIT_CYCLES+1)+1 cycles.
REQ-018 Read: both byte lanes are enabled and sram_oe_n=0 during LO and HI.
REQ-019 Read: sram_dq_i SHALL be sampled on the last cycle of LO into readdata[15:0] and on the last cycle of HI into readdata[31:16].
REQ-020 readdata SHALL update one cycle after DONE (read latency 1) and hold stable until the next read completes.
REQ-021 Write: sram_dq_oe=1 for the whole phase; sram_dq_o is writedata[15:0] in LO and writedata[31:16] in HI.
REQ-022 Write: sram_we_n=0 for every phase cycle except the last (address/data hold); ub_n/lb_n SHALL be the inverted byte_enable bits of the active half.
REQ-023 sram_ce_n SHALL be 0 only in LO or HI.
REQ-024 Request fields are latched at the IDLE accept; a request withdrawn mid-access (an Avalon violation) SHALL still complete.
REQ-025 A request asserted in the cycle after DONE SHALL be accepted from IDLE with no lost cycle.

Reset
REQ-026 While rst=0 on a clock edge: state=IDLE, counter=0, readdata=0, and the registered SRAM outputs reset to ce_n=oe_n=we_n=ub_n=lb_n=1, dq_oe=0, dq_o=0, sram_addr=0; waitrequest follows REQ-016 (high if read|write is asserted).
REQ-027 Reset mid-access SHALL abort with no further SRAM strobe; the aborted access never completes, and the master sees waitrequest until it re-issues.

Configuration
REQ-028 Macro AVALON_SRAM_HALF_SKIP_EN.
REQ-029 When defined, a write SHALL skip LO if byte_enable[1:0]=0 and skip HI if byte_enable[3:2]=0; byte_enable=0 SHALL go from IDLE straight to DONE.
REQ-030 When undefined, every access SHALL run both phases; reads never skip.

Structure
REQ-031 The FSM state enum and the WAIT_CYCLES legal bounds SHALL live in the shared core package; avalon_req_t/avalon_resp_t are reused unchanged.
REQ-032 The phase counter SHALL be one sub-module, sram_phase_timer (load, count, expire pulse).

Verification
REQ-033 Read, WAIT=1, addr 0x10, sram returns 0x5678 then 0x1234 -> waitrequest high 5 cycles, sram_addr 0x8 then 0x9, readdata=0x12345678 the cycle after DONE.
REQ-034 Write 0xDEADBEEF with be=1111 -> dq_o 0xBEEF then 0xDEAD, we_n low 1 cycle per phase, ub_n=lb_n=0.
REQ-035 Write with be=0100, SKIP_EN defined -> LO skipped, HI only, ub_n=1, lb_n=0, waitrequest high 3 cycles; SKIP_EN undefined -> 5 cycles with both lanes masked in LO.
REQ-036 Back-to-back read then write -> second access accepted the cycle after DONE; readdata of the first read is unchanged by the write.
REQ-037 rst=0 asserted during HI of a write -> next cycle all strobes high, dq_oe=0, state IDLE; the re-issued write completes normally.
REQ-038 read=write=1 together -> write is performed and readdata is unchanged.

Source files
------------

// File: rtl/avalon_sram_ctrl_pkg.sv
// Shared types for the Avalon-MM to 16-bit asynchronous SRAM bridge:
// bus request/response structs, FSM state encoding and wait-state bounds.
package avalon_sram_ctrl_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
  } avalon_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } sram_state_e;

  localparam int WAIT_CYCLES_MIN = 1;
  localparam int WAIT_CYCLES_MAX = 7;
  localparam int PHASE_CNT_W     = 3;

endpackage

// File: rtl/avalon_sram_ctrl_phase_timer.sv
// Half-word phase timer: loads WAIT_CYCLES on phase entry, counts down while
// the phase is active and flags the last cycle of the phase.
module sram_phase_timer
  import avalon_sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_en,
  output logic [PHASE_CNT_W-1:0] o_count,
  output logic                   o_expire
);

  logic [PHASE_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= PHASE_CNT_W'(WAIT_CYCLES);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - PHASE_CNT_W'(1);
    end
  end

  assign o_count  = r_cnt;
  assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/avalon_sram_ctrl.sv
// Avalon-MM 32-bit slave to 16-bit async SRAM: each word is two half-word phases.
// Optional AVALON_SRAM_HALF_SKIP_EN skips write phases whose byte enables are all zero.
module avalon_sram_ctrl
  import avalon_sram_ctrl_pkg::*;
#(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  avalon_req_t        dbus_avalon_req,
  output avalon_resp_t       dbus_avalon_resp,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n,
  output sram_state_e        o_dbg_state
);

  if ((WAIT_CYCLES < WAIT_CYCLES_MIN) || (WAIT_CYCLES > WAIT_CYCLES_MAX)) begin : g_bad_wait_cycles
    $error("avalon_sram_ctrl: WAIT_CYCLES outside legal range");
  end

  sram_state_e             r_state, w_next_state;
  logic                    r_write;
  logic [SRAM_AW-2:0]      r_addr;
  logic [31:0]             r_wdata;
  logic [3:0]              r_be;
  logic [15:0]             r_rd_lo, r_rd_hi;
  logic [31:0]             r_readdata;
  logic [SRAM_AW-1:0]      r_sram_addr, w_sram_addr;
  logic [15:0]             r_dq_o, w_dq_o;
  logic                    r_dq_oe, w_dq_oe;
  logic                    r_ce_n, w_ce_n, r_oe_n, w_oe_n, r_we_n, w_we_n;
  logic                    r_ub_n, w_ub_n, r_lb_n, w_lb_n;
  logic                    w_req, w_accept, w_in_phase, w_next_in_phase, w_phase_entry;
  logic                    w_expire, w_next_last, w_half, w_skip_lo, w_skip_hi;
  logic [PHASE_CNT_W-1:0]  w_count;
  logic                    w_cur_write;
  logic [SRAM_AW-2:0]      w_cur_addr;
  logic [31:0]             w_cur_wdata;
  logic [3:0]              w_cur_be;
  logic                    w_unused_addr;

  assign w_req    = dbus_avalon_req.read | dbus_avalon_req.write;
  assign w_accept = (r_state == ST_IDLE) && w_req;
  assign w_unused_addr = ^{dbus_avalon_req.address[31:SRAM_AW+1], dbus_avalon_req.address[1:0]};

  // In IDLE the live request drives decisions; afterwards the latched copy does.
  assign w_cur_write = (r_state == ST_IDLE) ? dbus_avalon_req.write : r_write;
  assign w_cur_addr  = (r_state == ST_IDLE) ? dbus_avalon_req.address[SRAM_AW:2] : r_addr;
  assign w_cur_wdata = (r_state == ST_IDLE) ? dbus_avalon_req.writedata : r_wdata;
  assign w_cur_be    = (r_state == ST_IDLE) ? dbus_avalon_req.byte_enable : r_be;

`ifdef AVALON_SRAM_HALF_SKIP_EN
  assign w_skip_lo = w_cur_write && (w_cur_be[1:0] == 2'b00);
  assign w_skip_hi = w_cur_write && (w_cur_be[3:2] == 2'b00);
`else
  assign w_skip_lo = 1'b0;
  assign w_skip_hi = 1'b0;
`endif

  assign w_in_phase      = (r_state == ST_LO) || (r_state == ST_HI);
  assign w_next_in_phase = (w_next_state == ST_LO) || (w_next_state == ST_HI);
  assign w_phase_entry   = w_next_in_phase && (w_next_state != r_state);
  assign w_next_last     = (w_next_state == r_state) && (w_count == PHASE_CNT_W'(1));

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_phase_entry),
    .i_en     (w_in_phase),
    .o_count  (w_count),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_req) begin
        if (!w_skip_lo)      w_next_state = ST_LO;
        else if (!w_skip_hi) w_next_state = ST_HI;
        else                 w_next_state = ST_DONE;
      end
      ST_LO:   if (w_expire) w_next_state = w_skip_hi ? ST_DONE : ST_HI;
      ST_HI:   if (w_expire) w_next_state = ST_DONE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are computed for the upcoming state so the registered pins line up with it.
  always_comb begin
    w_half      = (w_next_state == ST_HI);
    w_sram_addr = r_sram_addr;
    w_dq_o      = r_dq_o;
    w_dq_oe     = 1'b0;
    w_ce_n      = 1'b1;
    w_oe_n      = 1'b1;
    w_we_n      = 1'b1;
    w_ub_n      = 1'b1;
    w_lb_n      = 1'b1;
    if (w_next_in_phase) begin
      w_ce_n      = 1'b0;
      w_sram_addr = {w_cur_addr, w_half};
      if (w_cur_write) begin
        w_dq_oe = 1'b1;
        w_dq_o  = w_half ? w_cur_wdata[31:16] : w_cur_wdata[15:0];
        w_we_n  = w_next_last;
        w_ub_n  = ~(w_half ? w_cur_be[3] : w_cur_be[1]);
        w_lb_n  = ~(w_half ? w_cur_be[2] : w_cur_be[0]);
      end else begin
        w_oe_n = 1'b0;
        w_ub_n = 1'b0;
        w_lb_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rd_lo     <= '0;
      r_rd_hi     <= '0;
      r_readdata  <= '0;
      r_sram_addr <= '0;
      r_dq_o      <= '0;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_lb_n      <= 1'b1;
    end else begin
      if (w_accept) begin
        r_write <= dbus_avalon_req.write;
        r_addr  <= dbus_avalon_req.address[SRAM_AW:2];
        r_wdata <= dbus_avalon_req.writedata;
        r_be    <= dbus_avalon_req.byte_enable;
      end
      if (!r_write && w_expire && (r_state == ST_LO)) r_rd_lo <= sram_dq_i;
      if (!r_write && w_expire && (r_state == ST_HI)) r_rd_hi <= sram_dq_i;
      if (!r_write && (r_state == ST_DONE))           r_readdata <= {r_rd_hi, r_rd_lo};
      r_sram_addr <= w_sram_addr;
      r_dq_o      <= w_dq_o;
      r_dq_oe     <= w_dq_oe;
      r_ce_n      <= w_ce_n;
      r_oe_n      <= w_oe_n;
      r_we_n      <= w_we_n;
      r_ub_n      <= w_ub_n;
      r_lb_n      <= w_lb_n;
    end
  end

  // waitrequest is combinational so it is already high in the IDLE accept cycle.
  assign dbus_avalon_resp = '{readdata: r_readdata,
                              waitrequest: w_req && (r_state != ST_DONE)};

  assign sram_addr   = r_sram_addr;
  assign sram_dq_o   = r_dq_o;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;
  assign sram_ub_n   = r_ub_n;
  assign sram_lb_n   = r_lb_n;
  assign o_dbg_state = r_state;

endmodule
